// File: rtl/axi4_align_job_master.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_align_job_master
//  Purpose  : AXI4-lite initiator that loads R/Q into the alignment accelerator,
//             starts it, polls for ready, collects and optionally stores results.
//  Revision : 1.0  initial release
// ============================================================================
module axi4_align_job_master #(
  parameter logic [31:0] R_ADDR     = 32'h3000_0000,
  parameter logic [31:0] Q_ADDR     = 32'h3100_0000,
  parameter logic [31:0] READY_ADDR = 32'h3200_0000,
  parameter logic [31:0] RALN_ADDR  = 32'h3300_0000,
  parameter logic [31:0] QALN_ADDR  = 32'h3400_0000,
  parameter logic [31:0] START_ADDR = 32'h3500_0000,
  parameter int unsigned POLL_MAX   = 1024,
  parameter bit          WRITEBACK  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [23:0] job_r,
  input  logic [23:0] job_q,
  input  logic [31:0] job_dst,
  output logic        done,
  output logic        done_timeout,
  output logic [31:0] done_r_aligned,
  output logic [31:0] done_q_aligned,
  output logic        busy,
  output logic        mem_axi_awvalid,
  output logic [31:0] mem_axi_awaddr,
  output logic [2:0]  mem_axi_awprot,
  input  logic        mem_axi_awready,
  output logic        mem_axi_wvalid,
  output logic [31:0] mem_axi_wdata,
  output logic [3:0]  mem_axi_wstrb,
  input  logic        mem_axi_wready,
  input  logic        mem_axi_bvalid,
  output logic        mem_axi_bready,
  output logic        mem_axi_arvalid,
  output logic [31:0] mem_axi_araddr,
  output logic [2:0]  mem_axi_arprot,
  input  logic        mem_axi_arready,
  input  logic        mem_axi_rvalid,
  output logic        mem_axi_rready,
  input  logic [31:0] mem_axi_rdata
);

  localparam int unsigned PW = $clog2(POLL_MAX + 1);
  localparam logic [PW-1:0] POLL_LIM = PW'(POLL_MAX);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_WR_R    = 4'd1;
  localparam logic [3:0] S_WR_Q    = 4'd2;
  localparam logic [3:0] S_WR_ST1  = 4'd3;
  localparam logic [3:0] S_WR_ST0  = 4'd4;
  localparam logic [3:0] S_POLL    = 4'd5;
  localparam logic [3:0] S_RD_RALN = 4'd6;
  localparam logic [3:0] S_RD_QALN = 4'd7;
  localparam logic [3:0] S_WB_R    = 4'd8;
  localparam logic [3:0] S_WB_Q    = 4'd9;
  localparam logic [3:0] S_DONE    = 4'd10;

  logic [3:0]    state_q, state_d;
  logic [23:0]   job_r_q, job_r_d;
  logic [23:0]   job_q_q, job_q_d;
  logic [31:0]   job_dst_q, job_dst_d;
  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
  logic [31:0]   raln_q, raln_d;
  logic [31:0]   qaln_q, qaln_d;
  logic          act_q, act_d;
  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic          bready_q, bready_d;
  logic          arvalid_q, arvalid_d;
  logic          rready_q, rready_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          done_q, done_d;
  logic          timeout_q, timeout_d;
  logic [31:0]   res_r_q, res_r_d;
  logic [31:0]   res_q_q, res_q_d;
  logic          busy_q, busy_d;
  logic          job_ready_q, job_ready_d;

  logic          is_wr, is_rd, wr_fin, rd_fin;
  logic [31:0]   wr_addr, wr_data, rd_addr;

  always_comb begin
    is_wr   = 1'b0;
    is_rd   = 1'b0;
    wr_addr = 32'd0;
    wr_data = 32'd0;
    rd_addr = 32'd0;
    case (state_q)
      S_WR_R:    begin is_wr = 1'b1; wr_addr = R_ADDR;           wr_data = {8'h00, job_r_q}; end
      S_WR_Q:    begin is_wr = 1'b1; wr_addr = Q_ADDR;           wr_data = {8'h00, job_q_q}; end
      S_WR_ST1:  begin is_wr = 1'b1; wr_addr = START_ADDR;       wr_data = 32'd1;            end
      S_WR_ST0:  begin is_wr = 1'b1; wr_addr = START_ADDR;       wr_data = 32'd0;            end
      S_WB_R:    begin is_wr = 1'b1; wr_addr = job_dst_q;        wr_data = raln_q;           end
      S_WB_Q:    begin is_wr = 1'b1; wr_addr = job_dst_q + 32'd4; wr_data = qaln_q;          end
      S_POLL:    begin is_rd = 1'b1; rd_addr = READY_ADDR; end
      S_RD_RALN: begin is_rd = 1'b1; rd_addr = RALN_ADDR;  end
      S_RD_QALN: begin is_rd = 1'b1; rd_addr = QALN_ADDR;  end
      default:   ;
    endcase
    wr_fin = is_wr && bready_q && mem_axi_bvalid;
    rd_fin = is_rd && rready_q && mem_axi_rvalid;
  end

  always_comb begin
    state_d    = state_q;
    job_r_d    = job_r_q;
    job_q_d    = job_q_q;
    job_dst_d  = job_dst_q;
    poll_cnt_d = poll_cnt_q;
    raln_d     = raln_q;
    qaln_d     = qaln_q;
    act_d      = act_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = 1'b0;
    timeout_d  = timeout_q;
    res_r_d    = res_r_q;
    res_q_d    = res_q_q;
    busy_d     = busy_q;

    // A state's transaction is launched one cycle after entry and retired on B/R.
    if (is_wr) begin
      if (!act_q) begin
        act_d     = 1'b1;
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        addr_d    = wr_addr;
        wdata_d   = wr_data;
      end else begin
        if (awvalid_q && mem_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && mem_axi_wready)   wvalid_d  = 1'b0;
        if (wr_fin) begin
          bready_d = 1'b0;
          act_d    = 1'b0;
        end else if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
        end
      end
    end

    if (is_rd) begin
      if (!act_q) begin
        act_d     = 1'b1;
        arvalid_d = 1'b1;
        addr_d    = rd_addr;
      end else begin
        if (arvalid_q && mem_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
        if (rd_fin) begin
          rready_d = 1'b0;
          act_d    = 1'b0;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (job_valid && job_ready_q) begin
          job_r_d    = job_r;
          job_q_d    = job_q;
          job_dst_d  = job_dst;
          poll_cnt_d = '0;
          busy_d     = 1'b1;
          state_d    = S_WR_R;
        end
      end
      S_WR_R:   if (wr_fin) state_d = S_WR_Q;
      S_WR_Q:   if (wr_fin) state_d = S_WR_ST1;
      S_WR_ST1: if (wr_fin) state_d = S_WR_ST0;
      S_WR_ST0: if (wr_fin) state_d = S_POLL;
      S_POLL: begin
        if (rd_fin) begin
          if (mem_axi_rdata[0]) begin
            state_d = S_RD_RALN;
          end else begin
            poll_cnt_d = poll_cnt_q + 1'b1;
            if (poll_cnt_d == POLL_LIM) begin
              done_d    = 1'b1;
              timeout_d = 1'b1;
              res_r_d   = 32'd0;
              res_q_d   = 32'd0;
              state_d   = S_DONE;
            end
          end
        end
      end
      S_RD_RALN: begin
        if (rd_fin) begin
          raln_d  = mem_axi_rdata;
          state_d = S_RD_QALN;
        end
      end
      S_RD_QALN: begin
        if (rd_fin) begin
          qaln_d = mem_axi_rdata;
          if (WRITEBACK) begin
            state_d = S_WB_R;
          end else begin
            done_d    = 1'b1;
            timeout_d = 1'b0;
            res_r_d   = raln_q;
            res_q_d   = mem_axi_rdata;
            state_d   = S_DONE;
          end
        end
      end
      S_WB_R: if (wr_fin) state_d = S_WB_Q;
      S_WB_Q: begin
        if (wr_fin) begin
          done_d    = 1'b1;
          timeout_d = 1'b0;
          res_r_d   = raln_q;
          res_q_d   = qaln_q;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Registered so the job port stays closed during reset and in the DONE cycle.
    job_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      job_r_q     <= '0;
      job_q_q     <= '0;
      job_dst_q   <= '0;
      poll_cnt_q  <= '0;
      raln_q      <= '0;
      qaln_q      <= '0;
      act_q       <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      res_r_q     <= '0;
      res_q_q     <= '0;
      busy_q      <= 1'b0;
      job_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      job_r_q     <= job_r_d;
      job_q_q     <= job_q_d;
      job_dst_q   <= job_dst_d;
      poll_cnt_q  <= poll_cnt_d;
      raln_q      <= raln_d;
      qaln_q      <= qaln_d;
      act_q       <= act_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      res_r_q     <= res_r_d;
      res_q_q     <= res_q_d;
      busy_q      <= busy_d;
      job_ready_q <= job_ready_d;
    end
  end

  assign job_ready       = job_ready_q;
  assign done            = done_q;
  assign done_timeout    = timeout_q;
  assign done_r_aligned  = res_r_q;
  assign done_q_aligned  = res_q_q;
  assign busy            = busy_q;
  assign mem_axi_awvalid = awvalid_q;
  assign mem_axi_awaddr  = addr_q;
  assign mem_axi_awprot  = 3'b000;
  assign mem_axi_wvalid  = wvalid_q;
  assign mem_axi_wdata   = wdata_q;
  assign mem_axi_wstrb   = 4'hF;
  assign mem_axi_bready  = bready_q;
  assign mem_axi_arvalid = arvalid_q;
  assign mem_axi_araddr  = addr_q;
  assign mem_axi_arprot  = 3'b000;
  assign mem_axi_rready  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4_align_job_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi4_align_job_master
//  Purpose  : Directed bench for axi4_align_job_master with an AXI4-lite slave model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi4_align_job_master;

  localparam logic [31:0] R_A  = 32'h3000_0000;
  localparam logic [31:0] Q_A  = 32'h3100_0000;
  localparam logic [31:0] RDY_A = 32'h3200_0000;
  localparam logic [31:0] RA_A = 32'h3300_0000;
  localparam logic [31:0] QA_A = 32'h3400_0000;
  localparam logic [31:0] ST_A = 32'h3500_0000;
  localparam int A_POLL_MAX = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- DUT A: POLL_MAX=4, WRITEBACK=1 ----------------
  logic        a_job_valid = 1'b0, a_job_ready;
  logic [23:0] a_job_r = '0, a_job_q = '0;
  logic [31:0] a_job_dst = '0;
  logic        a_done, a_done_timeout, a_busy;
  logic [31:0] a_done_r, a_done_q;
  logic        a_awvalid, a_awready, a_wvalid, a_wready, a_bvalid, a_bready;
  logic        a_arvalid, a_arready, a_rvalid, a_rready;
  logic [31:0] a_awaddr, a_wdata, a_araddr, a_rdata;
  logic [2:0]  a_awprot, a_arprot;
  logic [3:0]  a_wstrb;

  axi4_align_job_master #(.POLL_MAX(A_POLL_MAX), .WRITEBACK(1'b1)) dut_a (
    .clk(clk), .reset(reset),
    .job_valid(a_job_valid), .job_ready(a_job_ready),
    .job_r(a_job_r), .job_q(a_job_q), .job_dst(a_job_dst),
    .done(a_done), .done_timeout(a_done_timeout),
    .done_r_aligned(a_done_r), .done_q_aligned(a_done_q), .busy(a_busy),
    .mem_axi_awvalid(a_awvalid), .mem_axi_awaddr(a_awaddr), .mem_axi_awprot(a_awprot),
    .mem_axi_awready(a_awready),
    .mem_axi_wvalid(a_wvalid), .mem_axi_wdata(a_wdata), .mem_axi_wstrb(a_wstrb),
    .mem_axi_wready(a_wready),
    .mem_axi_bvalid(a_bvalid), .mem_axi_bready(a_bready),
    .mem_axi_arvalid(a_arvalid), .mem_axi_araddr(a_araddr), .mem_axi_arprot(a_arprot),
    .mem_axi_arready(a_arready),
    .mem_axi_rvalid(a_rvalid), .mem_axi_rready(a_rready), .mem_axi_rdata(a_rdata)
  );

  // Slave A configuration (driven by the stimulus process only)
  int          cfg_ready_after = 1;
  int          cfg_aw_delay = 0;
  logic [31:0] cfg_raln = '0, cfg_qaln = '0;

  logic        sa_aw_got, sa_w_got, sa_ar_got;
  int          sa_aw_cnt;
  int          sa_poll = 0;
  logic [31:0] sa_awaddr, sa_wdata, sa_araddr;
  int          sa_log_n = 0;
  logic [31:0] sa_log_addr [0:255];
  logic [31:0] sa_log_data [0:255];
  logic        sa_log_wr   [0:255];
  logic [31:0] wk [0:255];
  int          sa_bhs = 0;
  int          sa_err = 0;

  always @(posedge clk) begin
    if (reset) begin
      a_awready <= 1'b0; a_wready <= 1'b0; a_bvalid <= 1'b0;
      a_arready <= 1'b0; a_rvalid <= 1'b0; a_rdata <= '0;
      sa_aw_got <= 1'b0; sa_w_got <= 1'b0; sa_ar_got <= 1'b0; sa_aw_cnt <= 0;
    end else begin
      a_awready <= 1'b0;
      a_wready  <= 1'b0;
      a_arready <= 1'b0;
      if (a_job_valid && a_job_ready) sa_poll <= 0;
      if (a_wvalid && !a_wready && !sa_w_got) begin
        a_wready <= 1'b1; sa_w_got <= 1'b1; sa_wdata <= a_wdata;
      end
      if (a_awvalid && !a_awready && !sa_aw_got && sa_w_got) begin
        if (sa_aw_cnt >= cfg_aw_delay) begin
          a_awready <= 1'b1; sa_aw_got <= 1'b1; sa_awaddr <= a_awaddr; sa_aw_cnt <= 0;
        end else begin
          sa_aw_cnt <= sa_aw_cnt + 1;
        end
      end
      if (sa_aw_got && sa_w_got && !a_bvalid) begin
        a_bvalid <= 1'b1;
        if (sa_log_n < 256) begin
          sa_log_addr[sa_log_n] <= sa_awaddr;
          sa_log_data[sa_log_n] <= sa_wdata;
          sa_log_wr[sa_log_n]   <= 1'b1;
          sa_log_n <= sa_log_n + 1;
        end
        if (sa_awaddr[31:25] == 7'b0100_000) wk[sa_awaddr[9:2]] <= sa_wdata;
      end
      if (a_bvalid && a_bready) begin
        a_bvalid <= 1'b0; sa_aw_got <= 1'b0; sa_w_got <= 1'b0; sa_bhs <= sa_bhs + 1;
      end
      if (a_arvalid && !a_arready && !sa_ar_got) begin
        a_arready <= 1'b1; sa_ar_got <= 1'b1; sa_araddr <= a_araddr;
      end
      if (sa_ar_got && !a_rvalid) begin
        a_rvalid <= 1'b1;
        if (sa_araddr == RDY_A) begin
          a_rdata <= (cfg_ready_after != 0 && sa_poll + 1 >= cfg_ready_after) ? 32'd1 : 32'd0;
          sa_poll <= sa_poll + 1;
        end else if (sa_araddr == RA_A) a_rdata <= cfg_raln;
        else if (sa_araddr == QA_A) a_rdata <= cfg_qaln;
        else a_rdata <= 32'hDEAD_0000;
        if (sa_log_n < 256) begin
          sa_log_addr[sa_log_n] <= sa_araddr;
          sa_log_data[sa_log_n] <= 32'd0;
          sa_log_wr[sa_log_n]   <= 1'b0;
          sa_log_n <= sa_log_n + 1;
        end
      end
      if (a_rvalid && a_rready) begin
        a_rvalid <= 1'b0; sa_ar_got <= 1'b0;
      end
    end
  end

  // Bus-rule monitor on DUT A: stability, drop-after-handshake, no overlap.
  logic        ck_aw_pend, ck_w_pend, ck_ar_pend, ck_aw_prev, ck_w_prev, ck_aw_hs, ck_w_hs;
  logic [31:0] ck_aw_addr, ck_w_data, ck_ar_addr;
  always @(posedge clk) begin
    int e;
    e = 0;
    if (reset) begin
      ck_aw_pend <= 1'b0; ck_w_pend <= 1'b0; ck_ar_pend <= 1'b0;
      ck_aw_prev <= 1'b0; ck_w_prev <= 1'b0; ck_aw_hs <= 1'b0; ck_w_hs <= 1'b0;
    end else begin
      if (ck_aw_pend && (!a_awvalid || a_awaddr != ck_aw_addr)) e++;
      if (ck_w_pend && (!a_wvalid || a_wdata != ck_w_data)) e++;
      if (ck_ar_pend && (!a_arvalid || a_araddr != ck_ar_addr)) e++;
      if (ck_aw_hs && a_awvalid) e++;
      if (ck_w_hs && a_wvalid) e++;
      if ((a_awvalid && !ck_aw_prev) != (a_wvalid && !ck_w_prev)) e++;
      if ((a_awvalid || a_wvalid || a_bready) && (a_arvalid || a_rready)) e++;
      if (a_bready && (a_awvalid || a_wvalid)) e++;
      if (a_awvalid && (a_awprot != 3'b000 || a_wstrb != 4'hF)) e++;
      if (a_arvalid && a_arprot != 3'b000) e++;
      ck_aw_pend <= a_awvalid && !a_awready; ck_aw_addr <= a_awaddr;
      ck_w_pend  <= a_wvalid && !a_wready;   ck_w_data  <= a_wdata;
      ck_ar_pend <= a_arvalid && !a_arready; ck_ar_addr <= a_araddr;
      ck_aw_hs   <= a_awvalid && a_awready;  ck_w_hs    <= a_wvalid && a_wready;
      ck_aw_prev <= a_awvalid;               ck_w_prev  <= a_wvalid;
      sa_err <= sa_err + e;
    end
  end

  int a_done_cnt = 0;
  always @(negedge clk) if (a_done) a_done_cnt = a_done_cnt + 1;

  // ---------------- DUT B: default POLL_MAX, WRITEBACK=0 ----------------
  logic        b_job_valid = 1'b0, b_job_ready;
  logic        b_done, b_done_timeout, b_busy;
  logic [31:0] b_done_r, b_done_q;
  logic        b_awvalid, b_awready, b_wvalid, b_wready, b_bvalid, b_bready;
  logic        b_arvalid, b_arready, b_rvalid, b_rready;
  logic [31:0] b_awaddr, b_wdata, b_araddr, b_rdata;
  logic [2:0]  b_awprot, b_arprot;
  logic [3:0]  b_wstrb;

  axi4_align_job_master #(.WRITEBACK(1'b0)) dut_b (
    .clk(clk), .reset(reset),
    .job_valid(b_job_valid), .job_ready(b_job_ready),
    .job_r(24'h414347), .job_q(24'h414747), .job_dst(32'h4000_0400),
    .done(b_done), .done_timeout(b_done_timeout),
    .done_r_aligned(b_done_r), .done_q_aligned(b_done_q), .busy(b_busy),
    .mem_axi_awvalid(b_awvalid), .mem_axi_awaddr(b_awaddr), .mem_axi_awprot(b_awprot),
    .mem_axi_awready(b_awready),
    .mem_axi_wvalid(b_wvalid), .mem_axi_wdata(b_wdata), .mem_axi_wstrb(b_wstrb),
    .mem_axi_wready(b_wready),
    .mem_axi_bvalid(b_bvalid), .mem_axi_bready(b_bready),
    .mem_axi_arvalid(b_arvalid), .mem_axi_araddr(b_araddr), .mem_axi_arprot(b_arprot),
    .mem_axi_arready(b_arready),
    .mem_axi_rvalid(b_rvalid), .mem_axi_rready(b_rready), .mem_axi_rdata(b_rdata)
  );

  logic        sb_awg, sb_wg, sb_arg;
  logic [31:0] sb_awaddr, sb_araddr;
  int          sb_wr_cnt = 0, sb_wb_cnt = 0;
  always @(posedge clk) begin
    if (reset) begin
      b_awready <= 1'b0; b_wready <= 1'b0; b_bvalid <= 1'b0;
      b_arready <= 1'b0; b_rvalid <= 1'b0; b_rdata <= '0;
      sb_awg <= 1'b0; sb_wg <= 1'b0; sb_arg <= 1'b0;
    end else begin
      b_awready <= b_awvalid && !b_awready && !sb_awg;
      b_wready  <= b_wvalid && !b_wready && !sb_wg;
      b_arready <= b_arvalid && !b_arready && !sb_arg;
      if (b_awvalid && b_awready) begin sb_awg <= 1'b1; sb_awaddr <= b_awaddr; end
      if (b_wvalid && b_wready) sb_wg <= 1'b1;
      if (sb_awg && sb_wg && !b_bvalid) begin
        b_bvalid <= 1'b1;
        sb_wr_cnt <= sb_wr_cnt + 1;
        if (sb_awaddr[31:28] == 4'h4) sb_wb_cnt <= sb_wb_cnt + 1;
      end
      if (b_bvalid && b_bready) begin b_bvalid <= 1'b0; sb_awg <= 1'b0; sb_wg <= 1'b0; end
      if (b_arvalid && b_arready) begin sb_arg <= 1'b1; sb_araddr <= b_araddr; end
      if (sb_arg && !b_rvalid) begin
        b_rvalid <= 1'b1;
        if (sb_araddr == RDY_A) b_rdata <= 32'd1;
        else if (sb_araddr == RA_A) b_rdata <= 32'hCAFE_0001;
        else if (sb_araddr == QA_A) b_rdata <= 32'hBEEF_0002;
        else b_rdata <= 32'd0;
      end
      if (b_rvalid && b_rready) begin b_rvalid <= 1'b0; sb_arg <= 1'b0; end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [23:0] r;
    logic [23:0] q;
    logic [31:0] dst;
    int          ready_after;
    int          aw_delay;
    logic [31:0] raln;
    logic [31:0] qaln;
    logic        exp_to;
    logic [31:0] exp_r;
    logic [31:0] exp_q;
  } vec_t;

  vec_t tv [4];

  // Check the bus log from index start against the transaction order a job must produce.
  task automatic chk_log(input string tag, input vec_t v, input int start);
    logic [31:0] ea [0:31];
    logic [31:0] ed [0:31];
    logic        ew [0:31];
    int n = 0;
    int polls;
    ea[n] = R_A;  ed[n] = {8'h00, v.r}; ew[n] = 1'b1; n++;
    ea[n] = Q_A;  ed[n] = {8'h00, v.q}; ew[n] = 1'b1; n++;
    ea[n] = ST_A; ed[n] = 32'd1;        ew[n] = 1'b1; n++;
    ea[n] = ST_A; ed[n] = 32'd0;        ew[n] = 1'b1; n++;
    polls = v.exp_to ? A_POLL_MAX : v.ready_after;
    for (int k = 0; k < polls; k++) begin ea[n] = RDY_A; ed[n] = 0; ew[n] = 1'b0; n++; end
    if (!v.exp_to) begin
      ea[n] = RA_A;  ed[n] = 0;      ew[n] = 1'b0; n++;
      ea[n] = QA_A;  ed[n] = 0;      ew[n] = 1'b0; n++;
      ea[n] = v.dst; ed[n] = v.raln; ew[n] = 1'b1; n++;
      ea[n] = v.dst + 32'd4; ed[n] = v.qaln; ew[n] = 1'b1; n++;
    end
    chk({tag, "_log_len"}, sa_log_n - start, n);
    for (int k = 0; k < n && start + k < 256 && k < sa_log_n - start; k++) begin
      chk($sformatf("%s_t%0d_addr", tag, k), sa_log_addr[start + k], ea[k]);
      chk($sformatf("%s_t%0d_wr", tag, k), {31'd0, sa_log_wr[start + k]}, {31'd0, ew[k]});
      if (ew[k]) chk($sformatf("%s_t%0d_data", tag, k), sa_log_data[start + k], ed[k]);
    end
  endtask

  task automatic run_job(input string tag, input vec_t v);
    int start, b0, d0, rviol;
    bit seen;
    cfg_ready_after = v.ready_after;
    cfg_aw_delay    = v.aw_delay;
    cfg_raln        = v.raln;
    cfg_qaln        = v.qaln;
    @(negedge clk);
    start = sa_log_n; b0 = sa_bhs; d0 = a_done_cnt;
    a_job_r = v.r; a_job_q = v.q; a_job_dst = v.dst; a_job_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (a_job_ready) seen = 1; else @(negedge clk);
    end
    chk({tag, "_accept_seen"}, {31'd0, seen}, 32'd1);
    @(negedge clk);
    a_job_valid = 1'b0;
    chk({tag, "_busy_after_accept"}, {31'd0, a_busy}, 32'd1);
    rviol = 0; seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (a_job_ready) rviol++;
      if (a_done) seen = 1; else @(negedge clk);
    end
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    chk({tag, "_ready_low_while_busy"}, rviol, 0);
    chk({tag, "_timeout"}, {31'd0, a_done_timeout}, {31'd0, v.exp_to});
    chk({tag, "_r_aligned"}, a_done_r, v.exp_r);
    chk({tag, "_q_aligned"}, a_done_q, v.exp_q);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, {31'd0, a_done}, 32'd0);
    chk({tag, "_done_count"}, a_done_cnt - d0, 1);
    chk({tag, "_idle_ready"}, {31'd0, a_job_ready}, 32'd1);
    chk({tag, "_idle_busy"}, {31'd0, a_busy}, 32'd0);
    chk({tag, "_r_held"}, a_done_r, v.exp_r);
    chk({tag, "_b_count"}, sa_bhs - b0, v.exp_to ? 4 : 6);
    chk_log(tag, v, start);
    if (!v.exp_to) begin
      chk({tag, "_wk_r"}, wk[v.dst[9:2]], v.raln);
      chk({tag, "_wk_q"}, wk[v.dst[9:2] + 8'd1], v.qaln);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vec_t ja, jb;
    int d0, start;
    bit seen;

    tv[0] = '{24'h414347, 24'h414747, 32'h4000_0100, 3, 0, 32'h0000_1234, 32'h0000_5678,
              1'b0, 32'h0000_1234, 32'h0000_5678};
    tv[1] = '{24'h0A0B0C, 24'h0D0E0F, 32'h4000_0200, 0, 0, 32'h0000_1111, 32'h0000_2222,
              1'b1, 32'h0, 32'h0};
    tv[2] = '{24'h112233, 24'h445566, 32'h41FF_FFF0, 1, 3, 32'h89AB_CDEF, 32'h0123_4567,
              1'b0, 32'h89AB_CDEF, 32'h0123_4567};
    tv[3] = '{24'hFFFFFF, 24'h000001, 32'h4000_0010, 2, 1, 32'hDEAD_BEEF, 32'h0000_0001,
              1'b0, 32'hDEAD_BEEF, 32'h0000_0001};

    repeat (3) @(negedge clk);
    chk("rst_job_ready", {31'd0, a_job_ready}, 32'd0);
    chk("rst_valids", {28'd0, a_awvalid, a_wvalid, a_arvalid, a_bready}, 32'd0);
    chk("rst_rready", {31'd0, a_rready}, 32'd0);
    chk("rst_done", {30'd0, a_done, a_done_timeout}, 32'd0);
    chk("rst_busy", {31'd0, a_busy}, 32'd0);
    chk("rst_done_r", a_done_r, 32'd0);
    chk("rst_done_q", a_done_q, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_job_ready", {31'd0, a_job_ready}, 32'd1);

    for (int i = 0; i < 3; i++) run_job($sformatf("job%0d", i), tv[i]);

    // Reset while a ready poll is outstanding.
    cfg_ready_after = 0; cfg_aw_delay = 0;
    d0 = a_done_cnt;
    @(negedge clk);
    a_job_r = 24'h010203; a_job_q = 24'h040506; a_job_dst = 32'h4000_0300; a_job_valid = 1'b1;
    @(negedge clk);
    a_job_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (a_arvalid && a_araddr == RDY_A) seen = 1; else @(negedge clk);
    end
    chk("rst4_poll_reached", {31'd0, seen}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst4_arvalid", {31'd0, a_arvalid}, 32'd0);
    chk("rst4_busy", {31'd0, a_busy}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst4_no_done", a_done_cnt - d0, 0);
    chk("rst4_idle_busy", {31'd0, a_busy}, 32'd0);
    run_job("job3", tv[3]);

    // Back-to-back jobs with job_valid held high throughout.
    ja = '{24'h414141, 24'h474747, 32'h4000_0200, 1, 0, 32'hAAAA_0001, 32'hAAAA_0002,
           1'b0, 32'hAAAA_0001, 32'hAAAA_0002};
    jb = '{24'h434343, 24'h414341, 32'h4100_0300, 2, 0, 32'hBBBB_0001, 32'hBBBB_0002,
           1'b0, 32'hBBBB_0001, 32'hBBBB_0002};
    cfg_ready_after = ja.ready_after; cfg_raln = ja.raln; cfg_qaln = ja.qaln; cfg_aw_delay = 0;
    @(negedge clk);
    a_job_r = ja.r; a_job_q = ja.q; a_job_dst = ja.dst; a_job_valid = 1'b1;
    start = sa_log_n;
    @(negedge clk);
    a_job_r = jb.r; a_job_q = jb.q; a_job_dst = jb.dst;
    chk("b2b_a_busy", {31'd0, a_busy}, 32'd1);
    seen = 0; d0 = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (a_job_ready) d0++;
      if (a_done) seen = 1; else @(negedge clk);
    end
    chk("b2b_a_done_seen", {31'd0, seen}, 32'd1);
    chk("b2b_a_ready_low", d0, 0);
    chk("b2b_a_r", a_done_r, ja.exp_r);
    chk("b2b_a_q", a_done_q, ja.exp_q);
    chk_log("b2b_a", ja, start);
    cfg_ready_after = jb.ready_after; cfg_raln = jb.raln; cfg_qaln = jb.qaln;
    start = sa_log_n;
    @(negedge clk);
    chk("b2b_ready_after_done", {31'd0, a_job_ready}, 32'd1);
    @(negedge clk);
    chk("b2b_b_accepted", {30'd0, a_busy, a_job_ready}, 32'd2);
    a_job_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (a_done) seen = 1; else @(negedge clk);
    end
    chk("b2b_b_done_seen", {31'd0, seen}, 32'd1);
    chk("b2b_b_r", a_done_r, jb.exp_r);
    chk("b2b_b_q", a_done_q, jb.exp_q);
    chk("b2b_b_timeout", {31'd0, a_done_timeout}, 32'd0);
    @(negedge clk);
    chk_log("b2b_b", jb, start);
    chk("b2b_wk_a", wk[8'h80], ja.raln);
    chk("b2b_wk_b", wk[8'hC1], jb.qaln);

    chk("bus_rule_violations", sa_err, 0);

    // WRITEBACK=0 instance.
    @(negedge clk);
    b_job_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (b_job_ready) seen = 1; else @(negedge clk);
    end
    @(negedge clk);
    b_job_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (b_done) seen = 1; else @(negedge clk);
    end
    chk("nowb_done_seen", {31'd0, seen}, 32'd1);
    chk("nowb_timeout", {31'd0, b_done_timeout}, 32'd0);
    chk("nowb_r", b_done_r, 32'hCAFE_0001);
    chk("nowb_q", b_done_q, 32'hBEEF_0002);
    chk("nowb_wb_writes", sb_wb_cnt, 0);
    chk("nowb_total_writes", sb_wr_cnt, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
